// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared defaults and writeback-source encodings for the
//               register-file writeback arbiter and its holding slots.
// Contents    : DEFAULT_DW / DEFAULT_AW  - default data and address widths
//               SRC_ALU / SRC_MEM        - grant_src encodings
//               wb_src_e                 - enumerated view of the source
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_AW = 5;

    // grant_src encodings; also used as the index of the requester.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage : regfile_wb_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_slot.sv
`default_nettype none
// ============================================================================
// Module      : wb_slot
// Description : One-entry writeback holding slot. Accepts a request when
//               valid && ready at a rising edge; empties when granted. A slot
//               granted and refilled at the same edge holds the new request.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               valid / ready       - request handshake (ready ignores valid)
//               reqReg / reqData    - incoming destination register / data
//               grant               - arbiter retires the held entry this edge
//               full                - slot holds an unretired entry
//               slotReg / slotData  - held destination register / data
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slot
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    output logic          ready,
    input  logic [AW-1:0] reqReg,
    input  logic [DW-1:0] reqData,
    input  logic          grant,
    output logic          full,
    output logic [AW-1:0] slotReg,
    output logic [DW-1:0] slotData
);

    logic          r_full;
    logic [AW-1:0] r_reg;
    logic [DW-1:0] r_data;
    logic          w_accept;

    // A grant frees the slot at this edge, so a new request can land in the
    // same cycle without a bubble.
    assign ready    = !r_full || grant;
    assign w_accept = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_reg  <= reqReg;
            r_data <= reqData;
        end else if (grant) begin
            r_full <= 1'b0;
        end
    end

    assign full     = r_full;
    assign slotReg  = r_reg;
    assign slotData = r_data;

endmodule : wb_slot
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates ALU and load-path writebacks onto the single
//               register-file write port. Each source owns a one-entry slot;
//               one full slot is granted per cycle (round-robin when both are
//               full) into a registered output stage. Also reports whether a
//               decode read address has an unretired write in flight.
// Ports       : clk, rst                        - clock, sync active-high reset
//               alu_valid/ready/reg/data        - ALU writeback request
//               mem_valid/ready/reg/data        - load writeback request
//               RegWrite/WriteRegister/WriteData- registered RF write port
//               grant_src                       - 0 = ALU, 1 = MEM
//               rd1_addr/rd2_addr               - decode read addresses
//               rd1_pending/rd2_pending         - unretired write to address
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_reg,
    input  logic [DW-1:0] mem_data,
    output logic          RegWrite,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData,
    output logic          grant_src,
    input  logic [AW-1:0] rd1_addr,
    input  logic [AW-1:0] rd2_addr,
    output logic          rd1_pending,
    output logic          rd2_pending
);

    logic          w_aluFull;
    logic [AW-1:0] w_aluSlotReg;
    logic [DW-1:0] w_aluSlotData;
    logic          w_memFull;
    logic [AW-1:0] w_memSlotReg;
    logic [DW-1:0] w_memSlotData;

    logic          w_grantAlu;
    logic          w_grantMem;
    logic          w_anyGrant;
    logic          w_contend;
    logic [AW-1:0] w_grantReg;
    logic [DW-1:0] w_grantData;

    // Round-robin pointer: names the side that wins the next contention.
    logic          r_rr;
    logic          r_regWrite;
    logic [AW-1:0] r_writeRegister;
    logic [DW-1:0] r_writeData;
    logic          r_grantSrc;

    // ------------------------------------------------------------------
    // Holding slots
    // ------------------------------------------------------------------
    wb_slot #(
        .DW (DW),
        .AW (AW)
    ) u_aluSlot (
        .clk      (clk),
        .rst      (rst),
        .valid    (alu_valid),
        .ready    (alu_ready),
        .reqReg   (alu_reg),
        .reqData  (alu_data),
        .grant    (w_grantAlu),
        .full     (w_aluFull),
        .slotReg  (w_aluSlotReg),
        .slotData (w_aluSlotData)
    );

    wb_slot #(
        .DW (DW),
        .AW (AW)
    ) u_memSlot (
        .clk      (clk),
        .rst      (rst),
        .valid    (mem_valid),
        .ready    (mem_ready),
        .reqReg   (mem_reg),
        .reqData  (mem_data),
        .grant    (w_grantMem),
        .full     (w_memFull),
        .slotReg  (w_memSlotReg),
        .slotData (w_memSlotData)
    );

    // ------------------------------------------------------------------
    // Arbitration: a lone full slot always wins; on contention rr decides.
    // Grants depend only on slot state, so ready never depends on valid.
    // ------------------------------------------------------------------
    always_comb begin
        w_contend   = w_aluFull && w_memFull;
        w_grantAlu  = w_aluFull && (!w_memFull || (r_rr == SRC_ALU));
        w_grantMem  = w_memFull && (!w_aluFull || (r_rr == SRC_MEM));
        w_anyGrant  = w_grantAlu || w_grantMem;
        w_grantReg  = w_aluSlotReg;
        w_grantData = w_aluSlotData;
        if (w_grantMem) begin
            w_grantReg  = w_memSlotReg;
            w_grantData = w_memSlotData;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and registered write port.
    // Writes to register 0 retire normally but never raise RegWrite.
    // Address/data/source hold their last grant while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr            <= SRC_ALU;
            r_regWrite      <= 1'b0;
            r_writeRegister <= '0;
            r_writeData     <= '0;
            r_grantSrc      <= SRC_ALU;
        end else begin
            if (w_contend) begin
                r_rr <= ~r_rr;
            end
            r_regWrite <= w_anyGrant && (w_grantReg != '0);
            if (w_anyGrant) begin
                r_writeRegister <= w_grantReg;
                r_writeData     <= w_grantData;
                r_grantSrc      <= w_grantMem ? SRC_MEM : SRC_ALU;
            end
        end
    end

    assign RegWrite      = r_regWrite;
    assign WriteRegister = r_writeRegister;
    assign WriteData     = r_writeData;
    assign grant_src     = r_grantSrc;

    // ------------------------------------------------------------------
    // Pending-write detection for decode. The output stage only counts
    // while RegWrite is high: an idle stage keeps a stale address.
    // ------------------------------------------------------------------
    always_comb begin
        rd1_pending = (rd1_addr != '0) &&
                      ((w_aluFull && (w_aluSlotReg == rd1_addr)) ||
                       (w_memFull && (w_memSlotReg == rd1_addr)) ||
                       (r_regWrite && (r_writeRegister == rd1_addr)));
        rd2_pending = (rd2_addr != '0) &&
                      ((w_aluFull && (w_aluSlotReg == rd2_addr)) ||
                       (w_memFull && (w_memSlotReg == rd2_addr)) ||
                       (r_regWrite && (r_writeRegister == rd2_addr)));
    end

endmodule : regfile_wb_arbiter
`default_nettype wire
